// File: rtl/popcount_accum.sv
// rtl/popcount_accum.sv - pipelined beat popcount with per-frame accumulation
// Build option POPCOUNT_ACCUM_SAT_EN: saturating frame accumulator (default wraps).
module popcount_accum #(
  parameter int DATA_W  = 128,
  parameter int GROUP_W = 16,
  parameter int ACC_W   = 16,
  localparam int NG     = DATA_W / GROUP_W,
  localparam int CNT_W  = $clog2(DATA_W + 1),
  localparam int GRP_CW = $clog2(GROUP_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic              clear,
  output logic              beat_valid,
  output logic [CNT_W-1:0]  beat_count,
  output logic              frame_valid,
  output logic [ACC_W-1:0]  frame_sum,
  output logic              frame_ovf
);

  logic [GRP_CW-1:0] grp_cnt_d [NG];
  logic [GRP_CW-1:0] s1_grp    [NG];
  logic              s1_valid;
  logic              s1_last;
  logic [CNT_W-1:0]  beat_sum_d;
  logic              s2_last;
  logic [ACC_W-1:0]  acc;
  logic              sticky;
  logic [ACC_W:0]    acc_next;
  logic              carry;
  logic [ACC_W-1:0]  acc_upd;

  always_comb begin
    for (int g = 0; g < NG; g++) begin
      grp_cnt_d[g] = '0;
      for (int b = 0; b < GROUP_W; b++) begin
        grp_cnt_d[g] = grp_cnt_d[g] + GRP_CW'(in_data[g*GROUP_W + b]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      for (int g = 0; g < NG; g++) s1_grp[g] <= '0;
    end else begin
      s1_valid <= in_valid & ~clear;
      if (in_valid & ~clear) begin
        s1_last <= in_last;
        s1_grp  <= grp_cnt_d;
      end
    end
  end

  always_comb begin
    beat_sum_d = '0;
    for (int g = 0; g < NG; g++) beat_sum_d = beat_sum_d + CNT_W'(s1_grp[g]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_valid <= 1'b0;
      beat_count <= '0;
      s2_last    <= 1'b0;
    end else begin
      beat_valid <= s1_valid & ~clear;
      if (s1_valid & ~clear) begin
        beat_count <= beat_sum_d;
        s2_last    <= s1_last;
      end
    end
  end

  // One extra bit on the add exposes the carry used for overflow flagging.
  always_comb begin
    acc_next = {1'b0, acc} + (ACC_W+1)'(beat_count);
    carry    = acc_next[ACC_W];
`ifdef POPCOUNT_ACCUM_SAT_EN
    acc_upd  = carry ? {ACC_W{1'b1}} : acc_next[ACC_W-1:0];
`else
    acc_upd  = acc_next[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc         <= '0;
      sticky      <= 1'b0;
      frame_valid <= 1'b0;
      frame_sum   <= '0;
      frame_ovf   <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (clear) begin
        acc    <= '0;
        sticky <= 1'b0;
      end else if (beat_valid) begin
        if (s2_last) begin
          frame_sum   <= acc_upd;
          frame_ovf   <= sticky | carry;
          frame_valid <= 1'b1;
          acc         <= '0;
          sticky      <= 1'b0;
        end else begin
          acc    <= acc_upd;
          sticky <= sticky | carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_accum.sv
// tb/tb_popcount_accum.sv - randomized and directed checks of popcount_accum against a frame-total model
module tb_popcount_accum;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_last = 1'b0;
  logic         clear = 1'b0;

  logic         bv16, fv16, fo16, bv8, fv8, fo8;
  logic [7:0]   bc16, bc8;
  logic [15:0]  fs16;
  logic [7:0]   fs8;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  popcount_accum #(.DATA_W(128), .GROUP_W(16), .ACC_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .clear(clear), .beat_valid(bv16), .beat_count(bc16), .frame_valid(fv16),
    .frame_sum(fs16), .frame_ovf(fo16));

  popcount_accum #(.DATA_W(128), .GROUP_W(16), .ACC_W(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .clear(clear), .beat_valid(bv8), .beat_count(bc8), .frame_valid(fv8),
    .frame_sum(fs8), .frame_ovf(fo8));

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint fold(input longint total, input int w);
    longint mx = (longint'(1) << w) - 1;
`ifdef POPCOUNT_ACCUM_SAT_EN
    return (total > mx) ? mx : total;
`else
    return total & mx;
`endif
  endfunction

  // Model: a beat accepted at edge j shows as a beat at edge j+1 and joins its
  // frame at edge j+2, unless clear is high at any of those edges.
  bit     h_v [3];
  bit     h_l [3];
  bit     h_c [3];
  int     h_n [3];
  longint total;
  bit     exp_bv, exp_fv, exp_fo16, exp_fo8;
  int     exp_bc;
  longint exp_fs16, exp_fs8;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        h_v[i] = 0; h_l[i] = 0; h_c[i] = 0; h_n[i] = 0;
      end
      total = 0; exp_bv = 0; exp_fv = 0; exp_bc = 0;
      exp_fs16 = 0; exp_fs8 = 0; exp_fo16 = 0; exp_fo8 = 0;
    end else begin
      for (int i = 2; i > 0; i--) begin
        h_v[i] = h_v[i-1]; h_l[i] = h_l[i-1]; h_c[i] = h_c[i-1]; h_n[i] = h_n[i-1];
      end
      h_v[0] = in_valid; h_l[0] = in_last; h_c[0] = clear; h_n[0] = $countones(in_data);
      exp_bv = h_v[1] && !h_c[1] && !h_c[0];
      if (exp_bv) exp_bc = h_n[1];
      exp_fv = 0;
      if (h_c[0]) total = 0;
      else if (h_v[2] && !h_c[2] && !h_c[1]) begin
        total += h_n[2];
        if (h_l[2]) begin
          exp_fv   = 1;
          exp_fs16 = fold(total, 16);
          exp_fs8  = fold(total, 8);
          exp_fo16 = total > 65535;
          exp_fo8  = total > 255;
          total    = 0;
        end
      end
    end
  end

  int nbv = 0, nfv = 0, nfv8 = 0;
  longint last_fs16 = 0, last_fs8 = 0, last_fo8 = 0;

  always @(negedge clk) begin
    if (!rst) begin
      check("beat_valid16", bv16, exp_bv);
      check("beat_count16", bc16, exp_bc);
      check("beat_valid8", bv8, exp_bv);
      check("beat_count8", bc8, exp_bc);
      check("frame_valid16", fv16, exp_fv);
      check("frame_sum16", fs16, exp_fs16);
      check("frame_ovf16", fo16, exp_fo16);
      check("frame_valid8", fv8, exp_fv);
      check("frame_sum8", fs8, exp_fs8);
      check("frame_ovf8", fo8, exp_fo8);
      if (bv16) nbv++;
      if (fv16) begin nfv++; last_fs16 = fs16; end
      if (fv8) begin nfv8++; last_fs8 = fs8; last_fo8 = fo8; end
    end
  end

  task automatic drive(input bit v, input logic [127:0] d, input bit l, input bit c);
    in_valid = v; in_data = d; in_last = l; clear = c;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, '0, 0, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_bv"}, bv16 | bv8, 0);
    check({tag, "_bc"}, bc16 | bc8, 0);
    check({tag, "_fv"}, fv16 | fv8, 0);
    check({tag, "_fs"}, fs16 | 16'(fs8), 0);
    check({tag, "_fo"}, fo16 | fo8, 0);
  endtask

  logic [127:0] ones = '1;
  int b0, f0, f80;

  initial begin
    @(negedge clk);
    check_zero_outputs("reset_state");
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single all-ones beat closing its own frame.
    drive(1, ones, 1, 0);
    drive(0, '0, 0, 0);
    check("t2_beat_valid", bv16, 1);
    check("t2_beat_count", bc16, 128);
    drive(0, '0, 0, 0);
    check("t2_frame_valid", fv16, 1);
    check("t2_frame_sum", fs16, 128);
    check("t2_frame_ovf", fo16, 0);
    idle(2);

    // Four back-to-back 64-bit beats.
    #1; b0 = nbv; f0 = nfv;
    for (int i = 0; i < 4; i++) drive(1, {16{8'h0F}}, i == 3, 0);
    idle(4);
    #1;
    check("t3_beat_pulses", nbv - b0, 4);
    check("t3_frame_pulses", nfv - f0, 1);
    check("t3_frame_sum", last_fs16, 256);

    // Three all-ones beats into the 8-bit accumulator.
    #1; f80 = nfv8;
    for (int i = 0; i < 3; i++) drive(1, ones, i == 2, 0);
    idle(4);
    #1;
    check("t4_frame_pulses8", nfv8 - f80, 1);
`ifdef POPCOUNT_ACCUM_SAT_EN
    check("t4_frame_sum8", last_fs8, 255);
`else
    check("t4_frame_sum8", last_fs8, 128);
`endif
    check("t4_frame_ovf8", last_fo8, 1);
    check("t4_frame_sum16", last_fs16, 384);

    // Clear drops two in-flight beats; next frame starts from zero.
    #1; f0 = nfv;
    drive(1, ones >> 28, 0, 0);
    drive(1, ones >> 28, 0, 0);
    drive(0, '0, 0, 1);
    drive(1, 128'h1F, 1, 0);
    idle(4);
    #1;
    check("t5_frame_pulses", nfv - f0, 1);
    check("t5_frame_sum", last_fs16, 5);

    // Bubbles between beats, then clear coincident with last at S3.
    #1; f0 = nfv;
    drive(1, 128'h3FF, 0, 0); idle(2);
    drive(1, 128'hFFFFF, 0, 0); idle(2);
    drive(1, 128'h3FFF_FFFF, 1, 0);
    idle(4);
    #1;
    check("t6_frame_pulses", nfv - f0, 1);
    check("t6_frame_sum", last_fs16, 60);
    #1; f0 = nfv;
    drive(1, 128'hFF, 0, 0);
    drive(1, 128'hFF, 1, 0);
    drive(0, '0, 0, 0);
    drive(0, '0, 0, 1);
    idle(3);
    #1;
    check("t6_clear_wins", nfv - f0, 0);
    drive(1, 128'h7F, 1, 0);
    idle(4);
    #1;
    check("t6_next_frame_sum", last_fs16, 7);

    // Randomized traffic with an asynchronous reset in the middle.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [127:0] d;
      int mode;
      mode = $urandom_range(0, 9);
      d = {$urandom, $urandom, $urandom, $urandom};
      if (mode == 0) d = ones;
      else if (mode == 1) d = '0;
      else if (mode == 2) d = d & {$urandom, $urandom, $urandom, $urandom};
      if (cyc == 1500) begin
        #2 rst = 1'b1;
        #1 check_zero_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        check_zero_outputs("rst_held");
        rst = 1'b0;
        #1; f0 = nfv;
        idle(4);
        #1;
        check("rst_no_pulse", nfv - f0, 0);
      end
      drive($urandom_range(0, 9) < 7, d, $urandom_range(0, 4) == 0,
            $urandom_range(0, 49) == 0);
    end
    idle(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
